// File: rtl/cpu_defs.sv
// ----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the 32-bit MIPS datapath:
//   DATA_WIDTH   - datapath width (only 32 is supported)
//   alu_op_e     - ALU operation codes driven on alu_op
//   src_b_sel_e  - encodings of the ALU B operand select
//   uses_rt()    - whether an instruction actually reads its rt register
// ----------------------------------------------------------------------------
package cpu_defs;

    localparam int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_AND          = 4'd0,
        ALU_OR           = 4'd1,
        ALU_ADD          = 4'd2,
        ALU_LF_16        = 4'd3,
        ALU_UNSIGNED_SLT = 4'd4,
        ALU_SLL          = 4'd5,
        ALU_SUB          = 4'd6,
        ALU_SIGNED_SLT   = 4'd7
    } alu_op_e;

    // Encoding 3 is unassigned and behaves like SRC_B_RT.
    typedef enum logic [1:0] {
        SRC_B_RT   = 2'd0,
        SRC_B_SIMM = 2'd1,
        SRC_B_ZIMM = 2'd2
    } src_b_sel_e;

    // rt is a real source when it feeds B or supplies store data.
    function automatic logic uses_rt(input logic [1:0] src_b_sel, input logic mem_wen);
        return ((src_b_sel != SRC_B_SIMM) && (src_b_sel != SRC_B_ZIMM)) || mem_wen;
    endfunction

endpackage

// File: rtl/exe_operand_stage_if.sv
// ----------------------------------------------------------------------------
// exe_operand_stage_if
// Bundles every signal of the EXE operand stage except clk/rst.
//   slave  - the stage: receives decode payload, forwarding state, mem_allowin
//            and flush; drives allowin, ALU operands and EX/MEM fields.
//   master - the surrounding pipeline (decode, MEM, WB, hazard control).
// ----------------------------------------------------------------------------
interface exe_operand_stage_if #(
    parameter int DATA_WIDTH = 32
);
    // decode -> EXE
    logic                  de_valid;
    logic                  exe_allowin;
    logic [DATA_WIDTH-1:0] de_pc;
    logic [DATA_WIDTH-1:0] de_rs_val;
    logic [DATA_WIDTH-1:0] de_rt_val;
    logic [4:0]            de_rs;
    logic [4:0]            de_rt;
    logic [4:0]            de_dest;
    logic [15:0]           de_imm;
    logic [4:0]            de_shamt;
    logic [3:0]            de_aluop;
    logic                  de_src_a_sel;
    logic [1:0]            de_src_b_sel;
    logic                  de_reg_wen;
    logic                  de_mem_wen;
    logic                  de_is_load;
    // forwarding producers
    logic                  mem_fwd_valid;
    logic                  mem_fwd_reg_wen;
    logic                  mem_fwd_is_load;
    logic [4:0]            mem_fwd_dest;
    logic [DATA_WIDTH-1:0] mem_fwd_data;
    logic                  wb_fwd_valid;
    logic                  wb_fwd_reg_wen;
    logic [4:0]            wb_fwd_dest;
    logic [DATA_WIDTH-1:0] wb_fwd_data;
    // pipeline control
    logic                  mem_allowin;
    logic                  flush;
    // EXE -> ALU / MEM
    logic                  exe_to_mem_valid;
    logic [DATA_WIDTH-1:0] alu_a;
    logic [DATA_WIDTH-1:0] alu_b;
    logic [3:0]            alu_op;
    logic [DATA_WIDTH-1:0] exe_pc;
    logic [DATA_WIDTH-1:0] exe_store_data;
    logic [4:0]            exe_dest;
    logic                  exe_reg_wen;
    logic                  exe_mem_wen;
    logic                  exe_is_load;

    modport master (
        output de_valid, de_pc, de_rs_val, de_rt_val, de_rs, de_rt, de_dest,
               de_imm, de_shamt, de_aluop, de_src_a_sel, de_src_b_sel,
               de_reg_wen, de_mem_wen, de_is_load,
               mem_fwd_valid, mem_fwd_reg_wen, mem_fwd_is_load, mem_fwd_dest,
               mem_fwd_data, wb_fwd_valid, wb_fwd_reg_wen, wb_fwd_dest,
               wb_fwd_data, mem_allowin, flush,
        input  exe_allowin, exe_to_mem_valid, alu_a, alu_b, alu_op, exe_pc,
               exe_store_data, exe_dest, exe_reg_wen, exe_mem_wen, exe_is_load
    );

    modport slave (
        input  de_valid, de_pc, de_rs_val, de_rt_val, de_rs, de_rt, de_dest,
               de_imm, de_shamt, de_aluop, de_src_a_sel, de_src_b_sel,
               de_reg_wen, de_mem_wen, de_is_load,
               mem_fwd_valid, mem_fwd_reg_wen, mem_fwd_is_load, mem_fwd_dest,
               mem_fwd_data, wb_fwd_valid, wb_fwd_reg_wen, wb_fwd_dest,
               wb_fwd_data, mem_allowin, flush,
        output exe_allowin, exe_to_mem_valid, alu_a, alu_b, alu_op, exe_pc,
               exe_store_data, exe_dest, exe_reg_wen, exe_mem_wen, exe_is_load
    );

endinterface

// File: rtl/exe_fwd_mux.sv
// ----------------------------------------------------------------------------
// exe_fwd_mux
// Combinational operand bypass for one source register.
//   i_src_reg / i_stored        - register number and value held in EXE
//   i_mem_* / i_wb_*            - state of the MEM and WB producers
//   o_data                      - freshest architectural value of i_src_reg
// MEM wins over WB because it is younger. A MEM load has no data yet and is
// never forwarded; register 0 is hard-wired and never forwarded.
// ----------------------------------------------------------------------------
module exe_fwd_mux #(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       i_src_reg,
    input  logic [WIDTH-1:0] i_stored,
    input  logic             i_mem_valid,
    input  logic             i_mem_reg_wen,
    input  logic             i_mem_is_load,
    input  logic [4:0]       i_mem_dest,
    input  logic [WIDTH-1:0] i_mem_data,
    input  logic             i_wb_valid,
    input  logic             i_wb_reg_wen,
    input  logic [4:0]       i_wb_dest,
    input  logic [WIDTH-1:0] i_wb_data,
    output logic [WIDTH-1:0] o_data
);
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = (i_src_reg != 5'd0) && i_mem_valid && i_mem_reg_wen &&
                       !i_mem_is_load && (i_mem_dest == i_src_reg);
    assign w_wb_hit  = (i_src_reg != 5'd0) && i_wb_valid && i_wb_reg_wen &&
                       (i_wb_dest == i_src_reg);

    assign o_data = w_mem_hit ? i_mem_data :
                    w_wb_hit  ? i_wb_data  : i_stored;

endmodule

// File: rtl/exe_operand_stage.sv
// ----------------------------------------------------------------------------
// exe_operand_stage
// Decode-to-execute pipeline register and ALU operand front end.
//   clk, rst  - single clock, asynchronous active-high reset
//   bus       - exe_operand_stage_if.slave: decode payload with
//               de_valid/exe_allowin handshake, MEM/WB forwarding state,
//               mem_allowin and flush in; ALU operands, alu_op and the
//               EX/MEM fields with exe_to_mem_valid out.
// Payload is held while MEM stalls or a load-use hazard is pending; the held
// rs/rt values are refreshed from the bypass every stall cycle so a producer
// retiring during the stall is not lost.
// ----------------------------------------------------------------------------
module exe_operand_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    exe_operand_stage_if.slave bus
);
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_rs_val;
    logic [DATA_WIDTH-1:0] r_rt_val;
    logic [4:0]            r_rs;
    logic [4:0]            r_rt;
    logic [4:0]            r_dest;
    logic [15:0]           r_imm;
    logic [4:0]            r_shamt;
    logic [3:0]            r_aluop;
    logic                  r_src_a_sel;
    logic [1:0]            r_src_b_sel;
    logic                  r_reg_wen;
    logic                  r_mem_wen;
    logic                  r_is_load;

    logic [DATA_WIDTH-1:0] w_fwd_rs;
    logic [DATA_WIDTH-1:0] w_fwd_rt;
    logic                  w_mem_load;
    logic                  w_load_use;
    logic                  w_ready_go;
    logic                  w_allowin;

    exe_fwd_mux #(.WIDTH(DATA_WIDTH)) u_fwd_rs (
        .i_src_reg     (r_rs),
        .i_stored      (r_rs_val),
        .i_mem_valid   (bus.mem_fwd_valid),
        .i_mem_reg_wen (bus.mem_fwd_reg_wen),
        .i_mem_is_load (bus.mem_fwd_is_load),
        .i_mem_dest    (bus.mem_fwd_dest),
        .i_mem_data    (bus.mem_fwd_data),
        .i_wb_valid    (bus.wb_fwd_valid),
        .i_wb_reg_wen  (bus.wb_fwd_reg_wen),
        .i_wb_dest     (bus.wb_fwd_dest),
        .i_wb_data     (bus.wb_fwd_data),
        .o_data        (w_fwd_rs)
    );

    exe_fwd_mux #(.WIDTH(DATA_WIDTH)) u_fwd_rt (
        .i_src_reg     (r_rt),
        .i_stored      (r_rt_val),
        .i_mem_valid   (bus.mem_fwd_valid),
        .i_mem_reg_wen (bus.mem_fwd_reg_wen),
        .i_mem_is_load (bus.mem_fwd_is_load),
        .i_mem_dest    (bus.mem_fwd_dest),
        .i_mem_data    (bus.mem_fwd_data),
        .i_wb_valid    (bus.wb_fwd_valid),
        .i_wb_reg_wen  (bus.wb_fwd_reg_wen),
        .i_wb_dest     (bus.wb_fwd_dest),
        .i_wb_data     (bus.wb_fwd_data),
        .o_data        (w_fwd_rt)
    );

    // A load in MEM has no data yet; stall only if we really read its dest.
    assign w_mem_load = bus.mem_fwd_valid && bus.mem_fwd_reg_wen &&
                        bus.mem_fwd_is_load && (bus.mem_fwd_dest != 5'd0);
    assign w_load_use = w_mem_load &&
                        ((!r_src_a_sel && (bus.mem_fwd_dest == r_rs)) ||
                         (cpu_defs::uses_rt(r_src_b_sel, r_mem_wen) &&
                          (bus.mem_fwd_dest == r_rt)));

    assign w_ready_go = !(r_valid && w_load_use);
    assign w_allowin  = !r_valid || (w_ready_go && bus.mem_allowin);

    assign bus.exe_allowin      = w_allowin;
    assign bus.exe_to_mem_valid = r_valid && w_ready_go && !bus.flush;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_rs_val    <= '0;
            r_rt_val    <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_dest      <= '0;
            r_imm       <= '0;
            r_shamt     <= '0;
            r_aluop     <= '0;
            r_src_a_sel <= 1'b0;
            r_src_b_sel <= '0;
            r_reg_wen   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_is_load   <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_allowin) begin
            r_valid <= bus.de_valid;
            if (bus.de_valid) begin
                r_pc        <= bus.de_pc;
                r_rs_val    <= bus.de_rs_val;
                r_rt_val    <= bus.de_rt_val;
                r_rs        <= bus.de_rs;
                r_rt        <= bus.de_rt;
                r_dest      <= bus.de_dest;
                r_imm       <= bus.de_imm;
                r_shamt     <= bus.de_shamt;
                r_aluop     <= bus.de_aluop;
                r_src_a_sel <= bus.de_src_a_sel;
                r_src_b_sel <= bus.de_src_b_sel;
                r_reg_wen   <= bus.de_reg_wen;
                r_mem_wen   <= bus.de_mem_wen;
                r_is_load   <= bus.de_is_load;
            end
        end else begin
            // Stalled with a valid instruction: absorb any producer seen now.
            r_rs_val <= w_fwd_rs;
            r_rt_val <= w_fwd_rt;
        end
    end

    assign bus.alu_a = r_src_a_sel ? {{(DATA_WIDTH-5){1'b0}}, r_shamt} : w_fwd_rs;

    always_comb begin
        // NOTE: default first so every path assigns alu_b and no latch forms.
        bus.alu_b = w_fwd_rt;
        case (r_src_b_sel)
            cpu_defs::SRC_B_SIMM: bus.alu_b = {{(DATA_WIDTH-16){r_imm[15]}}, r_imm};
            cpu_defs::SRC_B_ZIMM: bus.alu_b = {{(DATA_WIDTH-16){1'b0}}, r_imm};
            default:              bus.alu_b = w_fwd_rt;
        endcase
    end

    assign bus.alu_op         = r_aluop;
    assign bus.exe_pc         = r_pc;
    assign bus.exe_store_data = w_fwd_rt;
    assign bus.exe_dest       = r_dest;
    assign bus.exe_reg_wen    = r_reg_wen;
    assign bus.exe_mem_wen    = r_mem_wen;
    assign bus.exe_is_load    = r_is_load;

endmodule

// File: tb/tb_exe_operand_stage.sv
// ----------------------------------------------------------------------------
// tb_exe_operand_stage
// Directed scenarios with literal expectations, then randomized traffic.
// A behavioural model of the held instruction predicts every output; one
// compare process checks the DUT against it on every falling edge.
// ----------------------------------------------------------------------------
module tb_exe_operand_stage;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    exe_operand_stage_if #(.DATA_WIDTH(32)) bus ();

    exe_operand_stage #(.DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic [15:0] imm;
        logic [4:0]  shamt;
        logic [3:0]  aluop;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic        reg_wen;
        logic        mem_wen;
        logic        is_load;
    } slot_t;

    slot_t m;

    // Architectural value of register r as seen right now by an instruction
    // that read 'stored' from the register file earlier.
    function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] stored);
        if (r == 5'd0) return stored;
        if (bus.mem_fwd_valid && bus.mem_fwd_reg_wen && !bus.mem_fwd_is_load &&
            bus.mem_fwd_dest == r) return bus.mem_fwd_data;
        if (bus.wb_fwd_valid && bus.wb_fwd_reg_wen && bus.wb_fwd_dest == r)
            return bus.wb_fwd_data;
        return stored;
    endfunction

    function automatic logic m_reads_rt(input slot_t s);
        return (s.b_sel == 2'd0) || (s.b_sel == 2'd3) || s.mem_wen;
    endfunction

    function automatic logic m_waiting_on_load(input slot_t s);
        logic [4:0] d;
        d = bus.mem_fwd_dest;
        if (!(s.valid && bus.mem_fwd_valid && bus.mem_fwd_reg_wen && bus.mem_fwd_is_load))
            return 1'b0;
        if (d == 5'd0) return 1'b0;
        return (!s.a_sel && d == s.rs) || (m_reads_rt(s) && d == s.rt);
    endfunction

    function automatic logic m_allowin(input slot_t s);
        return !s.valid || (!m_waiting_on_load(s) && bus.mem_allowin);
    endfunction

    function automatic logic [31:0] m_alu_b(input slot_t s);
        case (s.b_sel)
            2'd1:    return {{16{s.imm[15]}}, s.imm};
            2'd2:    return {16'h0000, s.imm};
            default: return m_fwd(s.rt, s.rt_val);
        endcase
    endfunction

    function automatic slot_t m_next(input slot_t s);
        slot_t n;
        n = s;
        if (bus.flush) begin
            n.valid = 1'b0;
        end else if (m_allowin(s)) begin
            n.valid = bus.de_valid;
            if (bus.de_valid) begin
                n.pc      = bus.de_pc;
                n.rs_val  = bus.de_rs_val;
                n.rt_val  = bus.de_rt_val;
                n.rs      = bus.de_rs;
                n.rt      = bus.de_rt;
                n.dest    = bus.de_dest;
                n.imm     = bus.de_imm;
                n.shamt   = bus.de_shamt;
                n.aluop   = bus.de_aluop;
                n.a_sel   = bus.de_src_a_sel;
                n.b_sel   = bus.de_src_b_sel;
                n.reg_wen = bus.de_reg_wen;
                n.mem_wen = bus.de_mem_wen;
                n.is_load = bus.de_is_load;
            end
        end else begin
            n.rs_val = m_fwd(s.rs, s.rs_val);
            n.rt_val = m_fwd(s.rt, s.rt_val);
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= m_next(m);
    end

    // ------------------------------------------------------------ checking
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("allowin",   32'(bus.exe_allowin),      32'(m_allowin(m)));
        check("to_mem",    32'(bus.exe_to_mem_valid),
              32'(m.valid && !m_waiting_on_load(m) && !bus.flush));
        check("alu_a",     bus.alu_a, m.a_sel ? {27'd0, m.shamt} : m_fwd(m.rs, m.rs_val));
        check("alu_b",     bus.alu_b, m_alu_b(m));
        check("alu_op",    32'(bus.alu_op),           32'(m.aluop));
        check("exe_pc",    bus.exe_pc,                m.pc);
        check("store",     bus.exe_store_data,        m_fwd(m.rt, m.rt_val));
        check("exe_dest",  32'(bus.exe_dest),         32'(m.dest));
        check("ctl",       {29'd0, bus.exe_reg_wen, bus.exe_mem_wen, bus.exe_is_load},
              {29'd0, m.reg_wen, m.mem_wen, m.is_load});
    end

    // ------------------------------------------------------------ stimulus
    task automatic idle();
        bus.de_valid        = 1'b0;
        bus.mem_fwd_valid   = 1'b0;
        bus.mem_fwd_reg_wen = 1'b0;
        bus.mem_fwd_is_load = 1'b0;
        bus.mem_fwd_dest    = 5'd0;
        bus.mem_fwd_data    = 32'd0;
        bus.wb_fwd_valid    = 1'b0;
        bus.wb_fwd_reg_wen  = 1'b0;
        bus.wb_fwd_dest     = 5'd0;
        bus.wb_fwd_data     = 32'd0;
        bus.mem_allowin     = 1'b1;
        bus.flush           = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] rs_val,
                         input logic [31:0] rt_val, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [15:0] imm,
                         input logic [4:0] shamt, input logic [3:0] op,
                         input logic a_sel, input logic [1:0] b_sel);
        bus.de_valid     = 1'b1;
        bus.de_pc        = pc;
        bus.de_rs_val    = rs_val;
        bus.de_rt_val    = rt_val;
        bus.de_rs        = rs;
        bus.de_rt        = rt;
        bus.de_dest      = 5'd9;
        bus.de_imm       = imm;
        bus.de_shamt     = shamt;
        bus.de_aluop     = op;
        bus.de_src_a_sel = a_sel;
        bus.de_src_b_sel = b_sel;
        bus.de_reg_wen   = 1'b1;
        bus.de_mem_wen   = 1'b0;
        bus.de_is_load   = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle();
        issue(32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 16'h0, 5'd0, 4'd0, 1'b0, 2'd0);
        bus.de_valid = 1'b0;
        #2;
        check("reset allowin", 32'(bus.exe_allowin), 32'd1);
        check("reset to_mem",  32'(bus.exe_to_mem_valid), 32'd0);
        check("reset alu_a",   bus.alu_a, 32'd0);
        check("reset alu_op",  32'(bus.alu_op), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // basic ADD issue
        issue(32'h100, 32'd5, 32'd7, 5'd1, 5'd2, 16'h0, 5'd0, 4'd2, 1'b0, 2'd0);
        tick(); idle(); #1;
        check("basic alu_a",  bus.alu_a, 32'd5);
        check("basic alu_b",  bus.alu_b, 32'd7);
        check("basic alu_op", 32'(bus.alu_op), 32'd2);
        check("basic to_mem", 32'(bus.exe_to_mem_valid), 32'd1);

        // immediate extension and shamt
        issue(32'h104, 32'd1, 32'd2, 5'd1, 5'd2, 16'hFFFE, 5'd0, 4'd2, 1'b0, 2'd1);
        tick(); idle(); #1;
        check("simm alu_b", bus.alu_b, 32'hFFFF_FFFE);
        issue(32'h108, 32'd1, 32'd2, 5'd1, 5'd2, 16'hFFFE, 5'd0, 4'd1, 1'b0, 2'd2);
        tick(); idle(); #1;
        check("zimm alu_b", bus.alu_b, 32'h0000_FFFE);
        issue(32'h10C, 32'd1, 32'd2, 5'd1, 5'd2, 16'h0, 5'd4, 4'd5, 1'b1, 2'd0);
        tick(); idle(); #1;
        check("sll alu_a",  bus.alu_a, 32'd4);
        check("sll alu_op", 32'(bus.alu_op), 32'd5);

        // forwarding priority and register-0 rule
        issue(32'h110, 32'h11, 32'd0, 5'd3, 5'd2, 16'h0, 5'd0, 4'd2, 1'b0, 2'd0);
        tick(); idle();
        bus.mem_fwd_valid = 1'b1; bus.mem_fwd_reg_wen = 1'b1;
        bus.mem_fwd_dest = 5'd3;  bus.mem_fwd_data = 32'hAA;
        bus.wb_fwd_valid = 1'b1;  bus.wb_fwd_reg_wen = 1'b1;
        bus.wb_fwd_dest = 5'd3;   bus.wb_fwd_data = 32'hBB;
        #1 check("fwd mem over wb", bus.alu_a, 32'hAA);
        bus.mem_fwd_dest = 5'd0;  bus.wb_fwd_dest = 5'd0;
        #1 check("fwd dest0 stored", bus.alu_a, 32'h11);
        bus.mem_fwd_valid = 1'b0; bus.wb_fwd_valid = 1'b0;
        issue(32'h114, 32'h22, 32'd0, 5'd0, 5'd2, 16'h0, 5'd0, 4'd2, 1'b0, 2'd0);
        tick(); idle();
        bus.mem_fwd_valid = 1'b1; bus.mem_fwd_reg_wen = 1'b1; bus.mem_fwd_data = 32'hAA;
        bus.wb_fwd_valid = 1'b1;  bus.wb_fwd_reg_wen = 1'b1;  bus.wb_fwd_data = 32'hBB;
        #1 check("fwd rs0 stored", bus.alu_a, 32'h22);

        // load-use stall on rt=8, then WB supplies the data
        idle();
        issue(32'h118, 32'd1, 32'h99, 5'd1, 5'd8, 16'h0, 5'd0, 4'd2, 1'b0, 2'd0);
        tick(); idle();
        bus.mem_fwd_valid = 1'b1; bus.mem_fwd_reg_wen = 1'b1;
        bus.mem_fwd_is_load = 1'b1; bus.mem_fwd_dest = 5'd8;
        #1;
        check("loaduse to_mem",  32'(bus.exe_to_mem_valid), 32'd0);
        check("loaduse allowin", 32'(bus.exe_allowin), 32'd0);
        tick(); idle();
        bus.wb_fwd_valid = 1'b1; bus.wb_fwd_reg_wen = 1'b1;
        bus.wb_fwd_dest = 5'd8;  bus.wb_fwd_data = 32'h1234;
        #1;
        check("loaduse issue",   32'(bus.exe_to_mem_valid), 32'd1);
        check("loaduse alu_b",   bus.alu_b, 32'h1234);

        // refresh while MEM stalls for 3 cycles
        idle();
        issue(32'h11C, 32'h10, 32'd0, 5'd4, 5'd2, 16'h0, 5'd0, 4'd2, 1'b0, 2'd0);
        tick(); idle();
        bus.mem_allowin = 1'b0;
        bus.wb_fwd_valid = 1'b1; bus.wb_fwd_reg_wen = 1'b1;
        bus.wb_fwd_dest = 5'd4;  bus.wb_fwd_data = 32'h55;
        #1 check("refresh c1", bus.alu_a, 32'h55);
        tick(); bus.wb_fwd_valid = 1'b0;
        #1 check("refresh c2", bus.alu_a, 32'h55);
        tick();
        #1 check("refresh c3", bus.alu_a, 32'h55);
        idle();

        // flush together with de_valid
        issue(32'h120, 32'd1, 32'd2, 5'd1, 5'd2, 16'h0, 5'd0, 4'd2, 1'b0, 2'd0);
        tick(); idle();
        issue(32'h124, 32'd3, 32'd4, 5'd1, 5'd2, 16'h0, 5'd0, 4'd6, 1'b0, 2'd0);
        bus.flush = 1'b1;
        #1 check("flush to_mem", 32'(bus.exe_to_mem_valid), 32'd0);
        tick(); idle();
        #1;
        check("flush empty to_mem",  32'(bus.exe_to_mem_valid), 32'd0);
        check("flush empty allowin", 32'(bus.exe_allowin), 32'd1);

        // flush while MEM is stalled
        issue(32'h128, 32'd1, 32'd2, 5'd1, 5'd2, 16'h0, 5'd0, 4'd2, 1'b0, 2'd0);
        tick(); idle();
        bus.mem_allowin = 1'b0; bus.flush = 1'b1;
        #1 check("flush stall allowin", 32'(bus.exe_allowin), 32'd0);
        tick(); bus.flush = 1'b0;
        #1 check("flush stall empty", 32'(bus.exe_allowin), 32'd1);
        idle();

        // reset in the middle of a stall
        issue(32'h400, 32'h77, 32'd2, 5'd1, 5'd2, 16'h0, 5'd0, 4'd6, 1'b0, 2'd0);
        tick(); idle();
        bus.mem_allowin = 1'b0;
        #1;
        check("pre-reset to_mem", 32'(bus.exe_to_mem_valid), 32'd1);
        check("pre-reset alu_op", 32'(bus.alu_op), 32'd6);
        rst = 1'b1;
        #1;
        check("midreset to_mem",  32'(bus.exe_to_mem_valid), 32'd0);
        check("midreset allowin", 32'(bus.exe_allowin), 32'd1);
        check("midreset alu_a",   bus.alu_a, 32'd0);
        check("midreset alu_b",   bus.alu_b, 32'd0);
        check("midreset alu_op",  32'(bus.alu_op), 32'd0);
        check("midreset pc",      bus.exe_pc, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle();

        // randomized traffic
        for (int i = 0; i < 2000; i++) begin
            tick();
            bus.de_valid        = ($urandom_range(0, 3) != 0);
            bus.de_pc           = $urandom();
            bus.de_rs_val       = $urandom();
            bus.de_rt_val       = $urandom();
            bus.de_rs           = 5'($urandom_range(0, 3));
            bus.de_rt           = 5'($urandom_range(0, 3));
            bus.de_dest         = 5'($urandom_range(0, 31));
            bus.de_imm          = 16'($urandom());
            bus.de_shamt        = 5'($urandom());
            bus.de_aluop        = 4'($urandom_range(0, 7));
            bus.de_src_a_sel    = ($urandom_range(0, 3) == 0);
            bus.de_src_b_sel    = 2'($urandom_range(0, 3));
            bus.de_reg_wen      = 1'($urandom());
            bus.de_mem_wen      = ($urandom_range(0, 3) == 0);
            bus.de_is_load      = ($urandom_range(0, 3) == 0);
            bus.mem_fwd_valid   = 1'($urandom());
            bus.mem_fwd_reg_wen = ($urandom_range(0, 3) != 0);
            bus.mem_fwd_is_load = ($urandom_range(0, 2) == 0);
            bus.mem_fwd_dest    = 5'($urandom_range(0, 3));
            bus.mem_fwd_data    = $urandom();
            bus.wb_fwd_valid    = 1'($urandom());
            bus.wb_fwd_reg_wen  = ($urandom_range(0, 3) != 0);
            bus.wb_fwd_dest     = 5'($urandom_range(0, 3));
            bus.wb_fwd_data     = $urandom();
            bus.mem_allowin     = ($urandom_range(0, 3) != 0);
            bus.flush           = ($urandom_range(0, 19) == 0);
        end

        idle();
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exe_operand_stage.md
# exe_operand_stage

Decode-to-execute pipeline register and operand front end for the 32-bit MIPS datapath. Captures a decoded instruction under a valid/allowin handshake and holds it while downstream stalls. It resolves RAW hazards by forwarding from MEM and WB, and refreshes held operands so forwarded data is never lost. It drives the A, B and ALUop inputs of the ALU directly and passes destination and control fields on to the EX/MEM boundary.

## Interface
- `DATA_WIDTH`, 32: datapath width; only 32 is supported.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `de_valid` in 1: decode holds a valid instruction.
- `exe_allowin` out 1: this stage accepts an instruction this cycle.
- `de_pc`, `de_rs_val`, `de_rt_val` in 32: PC and register-file read data.
- `de_rs`, `de_rt`, `de_dest` in 5: source and destination register numbers.
- `de_imm` in 16: instruction immediate.
- `de_shamt` in 5: shift amount.
- `de_aluop` in 4: ALU operation code.
- `de_src_a_sel` in 1: selects A. 0 = rs, 1 = zero-extended shamt.
- `de_src_b_sel` in 2: selects B. 0 = rt, 1 = sign-extended imm, 2 = zero-extended imm; 3 is treated as 0.
- `de_reg_wen`, `de_mem_wen`, `de_is_load` in 1: control fields passed through.
- `mem_fwd_valid`, `mem_fwd_reg_wen`, `mem_fwd_is_load` in 1: state of the MEM-stage producer.
- `mem_fwd_dest` in 5, `mem_fwd_data` in 32: MEM-stage destination and result.
- `wb_fwd_valid`, `wb_fwd_reg_wen` in 1; `wb_fwd_dest` in 5; `wb_fwd_data` in 32: state of the WB-stage producer.
- `mem_allowin` in 1: MEM stage accepts this cycle.
- `flush` in 1: kills the instruction held in EXE and blocks capture in the same cycle.
- `exe_to_mem_valid` out 1: instruction is valid and ready to leave EXE.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_op` out 4: ALU operation code.
- `exe_pc`, `exe_store_data` out 32: PC and forwarded rt value.
- `exe_dest` out 5: destination register number.
- `exe_reg_wen`, `exe_mem_wen`, `exe_is_load` out 1: control fields.

## Operation
- **Valid register:** `exe_valid` is internal.
  - `ready_go = !(exe_valid && load_use)`.
  - `load_use` = MEM producer has valid && reg_wen && is_load && dest≠0 && dest matches a source this instruction actually uses. rs is used when `src_a_sel`=0; rt is used when `src_b_sel`=0 or `mem_wen`=1.
- **Allowin:** `exe_allowin = !exe_valid || (ready_go && mem_allowin)`. `exe_to_mem_valid = exe_valid && ready_go && !flush`.
- **Update priority,** first match wins:
  - `flush`: `exe_valid` <= 0.
  - `exe_allowin`: `exe_valid` <= `de_valid`. All payload is captured only when `de_valid`=1.
  - Otherwise: hold.
- **Forwarding,** applied per source register (rs, rt):
  - The register number 0 never forwards.
  - If MEM matches (valid, reg_wen, dest equal, not load), use `mem_fwd_data`.
  - Else if WB matches (valid, reg_wen, dest equal), use `wb_fwd_data`.
  - Else use the stored value.
- **Refresh:** while `exe_valid` && !`exe_allowin`, the stored rs/rt values are overwritten with their forwarded values every cycle. A producer that retires during a stall is therefore still seen.
- **Operand selection:**
  - `alu_a` = `src_a_sel` ? {27'b0, shamt} : fwd_rs.
  - `alu_b` = fwd_rt, {{16{imm[15]}}, imm}, or {16'b0, imm}, per `src_b_sel`.
  - `exe_store_data` = fwd_rt.
- **ALU opcode:** `alu_op` is the registered ALUop, passed through unchanged.

## Timing
- **Latency:** an instruction accepted at edge N appears on the outputs after N. It leaves at the first later edge where ready_go && mem_allowin && !flush.
- **Combinational paths:** `alu_a`, `alu_b`, `exe_store_data` and `exe_allowin` are combinational from registered state plus the fwd_* inputs. There is no combinational path from `de_*` to any output.
- **Reset values:** `exe_valid`=0 and every payload register is 0. Hence `alu_a`=0, `alu_b`=0, `alu_op`=4'b0000, `exe_to_mem_valid`=0, `exe_allowin`=1.
- **Reset mid-stall:** the held instruction is discarded immediately; nothing reaches MEM.
- **Load-use stall:** lasts exactly until the load leaves MEM. On the following cycle WB forwarding supplies the data.
- **Flush and `de_valid` together:** the stage becomes empty; the decode instruction is not captured.
- **Flush with `mem_allowin`=0:** the stage still becomes empty.

## Structure
- **Shared package `cpu_defs`:**
  - ALUop constants: AND 0, OR 1, ADD 2, LF_16 3, UNSIGNED_SLT 4, SLL 5, SUB 6, SIGNED_SLT 7.
  - `SRC_B_RT`/`SIMM`/`ZIMM` = 0/1/2.
  - `DATA_WIDTH`.
- **Sub-module:** `exe_fwd_mux`, instantiated twice (rs, rt). It is purely combinational and implements the MEM/WB priority and the register-0 rule.

## Test plan
- **Basic issue:** ADD with rs_val=5, rt_val=7, `src_b_sel`=0 → next cycle `alu_a`=5, `alu_b`=7, `alu_op`=2, `exe_to_mem_valid`=1.
- **Immediate extension:** imm=16'hFFFE with `src_b_sel`=1 → `alu_b`=32'hFFFF_FFFE; with `src_b_sel`=2 → `alu_b`=32'h0000_FFFE. SLL with shamt=4 and `src_a_sel`=1 → `alu_a`=4.
- **Forwarding priority:** rs=3; MEM dest=3 data=0xAA; WB dest=3 data=0xBB → `alu_a`=0xAA. With dest=0 at both stages → the stored value is used.
- **Load-use:** MEM load to dest=8 while the EXE instruction uses rt=8 → `exe_to_mem_valid`=0 and `exe_allowin`=0 for 1 cycle. Then WB data 0x1234 is forwarded and the instruction issues with `alu_b`=0x1234.
- **Refresh on stall:** hold `mem_allowin`=0 for 3 cycles; WB forwards 0x55 to rs in cycle 1 only → `alu_a` stays 0x55 in cycles 2–3.
- **Flush and reset:** flush together with `de_valid`=1 → `exe_valid`=0 next cycle. Asserting `rst` mid-stall → all outputs return to their reset values immediately.
